// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck core.
//  opcode_t : 3-bit instruction encoding used by the ROM and the datapath.
//  state_t  : sequencer control states.
//  is_data_op : true for opcodes handled by the datapath (everything except [ and ]).
package bf_pkg;

  typedef enum logic [2:0] {
    OP_IN   = 3'b000,
    OP_OUT  = 3'b001,
    OP_BACK = 3'b010,
    OP_IF   = 3'b011,
    OP_MOVL = 3'b100,
    OP_MOVR = 3'b101,
    OP_DEC  = 3'b110,
    OP_INC  = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SCAN,
    ST_HALT,
    ST_ERROR
  } state_t;

  function automatic logic is_data_op(input opcode_t op);
    return !(op == OP_IF || op == OP_BACK);
  endfunction

endpackage

// File: rtl/bf_loop_stack.sv
// LIFO of loop-start addresses for the sequencer.
//  clk, rst   : clock, async active-high reset (clears sp only)
//  clr        : synchronous clear of sp (new program run)
//  push, pop  : one operation per cycle; push ignored when full, pop ignored when empty
//  din        : address pushed
//  top        : entry at sp-1 (valid when !empty)
//  full/empty : occupancy flags
module bf_loop_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 10,
  parameter int SP_W  = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]      mem [DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-2:0]   top_idx;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp[SP_W-2:0] - 1'b1;
  assign top     = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 sp <= '0;
    else if (clr)            sp <= '0;
    else if (push && !full)  sp <= sp + 1'b1;
    else if (pop && !empty)  sp <= sp - 1'b1;
  end

  // Storage needs no reset: entries are only read below sp.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem[sp[SP_W-2:0]] <= din;
  end

endmodule

// File: rtl/bf_loop_sequencer.sv
// Program sequencer for the Brainfuck core.
//  Owns the PC, addresses the instruction ROM, hands data ops to the datapath
//  over valid/ready and resolves [ / ] itself (loop stack for back-jumps,
//  depth-counted forward scan for skipped loops).
//  clk, rst            : clock, async active-high reset
//  start               : begin at PC 0 (only from IDLE/HALT/ERROR)
//  rom_addr            : = pc
//  rom_code/rom_overrun: combinational ROM response for rom_addr
//  dp_op/dp_valid      : data op offered to the datapath
//  dp_ready            : datapath accepts dp_op at this edge
//  cell_zero           : current cell == 0
//  busy/halted/error   : EXEC|SCAN / normal end / sticky fault
module bf_loop_sequencer
  import bf_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_code,
  input  logic              rom_overrun,
  output logic [2:0]        dp_op,
  output logic              dp_valid,
  input  logic              dp_ready,
  input  logic              cell_zero,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [ADDR_W-1:0] scan_depth, depth_nx;
  logic              push, pop, clr, full, empty;
  logic [ADDR_W-1:0] top;
  opcode_t           op;

  assign op       = opcode_t'(rom_code);
  assign rom_addr = pc;
  assign busy     = (state == ST_EXEC) || (state == ST_SCAN);
  assign halted   = (state == ST_HALT);
  assign error    = (state == ST_ERROR);

  bf_loop_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (pc),
    .top   (top),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      scan_depth <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      scan_depth <= depth_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    depth_nx = scan_depth;
    push     = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    dp_valid = 1'b0;
    dp_op    = OP_INC;
    case (state)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (start) begin
          state_nx = ST_EXEC;
          pc_nx    = '0;
          depth_nx = '0;
          clr      = 1'b1;
        end
      end
      ST_EXEC: begin
        // Overrun wins over whatever rom_code shows past the program end.
        if (rom_overrun) begin
          state_nx = ST_HALT;
        end else if (is_data_op(op)) begin
          dp_valid = 1'b1;
          dp_op    = rom_code;
          if (dp_ready) pc_nx = pc + 1'b1;
        end else if (op == OP_IF) begin
          if (cell_zero) begin
            state_nx = ST_SCAN;
            depth_nx = ADDR_W'(1);
            pc_nx    = pc + 1'b1;
          end else if (full) begin
            state_nx = ST_ERROR;
          end else begin
            push  = 1'b1;
            pc_nx = pc + 1'b1;
          end
        end else begin
          // ']': loop again keeps the stack entry so the next pass reuses it.
          if (empty) begin
            state_nx = ST_ERROR;
          end else if (!cell_zero) begin
            pc_nx = top + 1'b1;
          end else begin
            pop   = 1'b1;
            pc_nx = pc + 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (rom_overrun) begin
          state_nx = ST_ERROR;
        end else begin
          pc_nx = pc + 1'b1;
          if (op == OP_IF) begin
            depth_nx = scan_depth + 1'b1;
          end else if (op == OP_BACK) begin
            depth_nx = scan_depth - 1'b1;
            if (scan_depth == ADDR_W'(1)) state_nx = ST_EXEC;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
